rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback requesters:

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_wb_slot.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Port 0 carries ALU results and port 1 carries load/MEM results.
package rf_pkg;

   localparam int unsigned REG_MEM_SIZE = 32;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned ADDR_W       = 5;
   localparam int unsigned N_PORTS      = 2;

   localparam int unsigned WB_ALU = 0;
   localparam int unsigned WB_MEM = 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding slot with a valid bit and a one-bit age stamp.
// The age bit is set once the entry has survived an edge without being granted.
module rf_wb_slot
   import rf_pkg::*;
(
   input  logic    i_clk,
   input  logic    i_rst,
   input  logic    i_load,
   input  wb_req_t i_req,
   input  logic    i_grant,
   output logic    o_valid,
   output logic    o_aged,
   output wb_req_t o_req
);

   logic    r_valid;
   logic    r_aged;
   wb_req_t r_req;

   // Grant only targets a full slot and load only an empty one, so they never collide.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_aged  <= 1'b0;
         r_req   <= '0;
      end else if (i_grant) begin
         r_valid <= 1'b0;
         r_aged  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_aged  <= 1'b0;
         r_req   <= i_req;
      end else if (r_valid) begin
         r_aged  <= 1'b1;
      end
   end

   assign o_valid = r_valid;
   assign o_aged  = r_aged;
   assign o_req   = r_req;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the RF write port between the ALU and MEM writeback slots (oldest first,
// round-robin on ties), registers the winning write and forwards pending writes to decode.
module rf_wb_arbiter
   import rf_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_PORTS-1:0]    req_valid,
   output logic [N_PORTS-1:0]    req_ready,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_data,
   output logic                  wb_we,
   output logic [ADDR_W-1:0]     wb_addr,
   output logic [DATA_W-1:0]     wb_data,
   input  logic [ADDR_W-1:0]     q_addr,
   output logic                  q_hit,
   output logic [DATA_W-1:0]     q_data,
   output logic                  idle
);

   logic [N_PORTS-1:0] w_valid;
   logic [N_PORTS-1:0] w_aged;
   logic [N_PORTS-1:0] w_load;
   logic [N_PORTS-1:0] w_grant;
   wb_req_t            w_in  [N_PORTS];
   wb_req_t            w_req [N_PORTS];
   logic               w_any;
   logic               w_both;
   logic               w_tie;
   logic               w_win;
   logic               w_new;

   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_data;
   logic               r_rr;

   assign req_ready = ~w_valid & {N_PORTS{~rst}};

   for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_slot
      assign w_in[gi].addr = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_in[gi].data = req_data[gi*DATA_W +: DATA_W];
      // R0 writes finish the handshake but are dropped here.
      assign w_load[gi]    = req_valid[gi] && req_ready[gi] && (w_in[gi].addr != '0);

      rf_wb_slot u_slot (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_load  (w_load[gi]),
         .i_req   (w_in[gi]),
         .i_grant (w_grant[gi]),
         .o_valid (w_valid[gi]),
         .o_aged  (w_aged[gi]),
         .o_req   (w_req[gi])
      );
   end

   assign w_any  = |w_valid;
   assign w_both = &w_valid;
   assign w_tie  = w_both && (w_aged[0] == w_aged[1]);
   // With both full and different ages, the aged slot is the older one.
   assign w_win  = w_both ? (w_tie ? r_rr : w_aged[1]) : w_valid[1];
   assign w_new  = ~w_win;
   assign w_grant = {w_any && w_win, w_any && !w_win};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_rr   <= 1'b0;
      end else begin
         r_we <= w_any;
         if (w_any) begin
            r_addr <= w_req[w_win].addr;
            r_data <= w_req[w_win].data;
         end
         if (w_tie) begin
            r_rr <= ~r_rr;
         end
      end
   end

   assign wb_we   = r_we;
   assign wb_addr = r_addr;
   assign wb_data = r_data;
   assign idle    = !r_we && !w_any;

   // Youngest pending write wins: the slot that would lose arbitration is the newer one.
   always_comb begin
      q_hit  = 1'b0;
      q_data = '0;
      if (q_addr != '0) begin
         if (w_valid[w_new] && (w_req[w_new].addr == q_addr)) begin
            q_hit  = 1'b1;
            q_data = w_req[w_new].data;
         end else if (w_valid[w_win] && (w_req[w_win].addr == q_addr)) begin
            q_hit  = 1'b1;
            q_data = w_req[w_win].data;
         end else if (r_we && (r_addr == q_addr)) begin
            q_hit  = 1'b1;
            q_data = r_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a timestamp-ordered behavioural model.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [9:0]  req_addr;
   logic [63:0] req_data;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  q_addr;
   logic        q_hit;
   logic [31:0] q_data;
   logic        idle;

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .q_addr    (q_addr),
      .q_hit     (q_hit),
      .q_data    (q_data),
      .idle      (idle)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   // Model: each slot carries the edge number at which it was accepted.
   bit          m_v  [2];
   logic [4:0]  m_a  [2];
   logic [31:0] m_d  [2];
   int          m_st [2];
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   int          m_rr;
   int          edge_n;

   logic [31:0] rf_dut [32];
   logic [31:0] rf_ref [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int winner();
      if (m_v[0] && m_v[1]) begin
         if (m_st[0] != m_st[1]) return (m_st[0] < m_st[1]) ? 0 : 1;
         return m_rr;
      end
      if (m_v[0]) return 0;
      if (m_v[1]) return 1;
      return -1;
   endfunction

   task automatic model_step();
      int w;
      bit pre_v [2];
      edge_n++;
      if (rst) begin
         m_v  = '{0, 0};
         m_we = 0;
         m_wa = '0;
         m_wd = '0;
         m_rr = 0;
      end else begin
         w     = winner();
         pre_v = m_v;
         if (w < 0) begin
            m_we = 0;
         end else begin
            m_we = 1;
            m_wa = m_a[w];
            m_wd = m_d[w];
            if (m_v[0] && m_v[1] && m_st[0] == m_st[1]) m_rr = 1 - m_rr;
            m_v[w] = 0;
         end
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && !pre_v[i] && req_addr[i*5 +: 5] != 5'd0) begin
               m_v[i]  = 1;
               m_a[i]  = req_addr[i*5 +: 5];
               m_d[i]  = req_data[i*32 +: 32];
               m_st[i] = edge_n;
            end
         end
      end
   endtask

   task automatic exp_q(output bit hit, output logic [31:0] dat);
      int best;
      hit  = 0;
      dat  = '0;
      best = -1;
      if (q_addr != 5'd0) begin
         for (int i = 0; i < 2; i++) begin
            if (m_v[i] && m_a[i] == q_addr) begin
               if (best < 0) best = i;
               else if (m_st[i] > m_st[best] || (m_st[i] == m_st[best] && best == m_rr)) best = i;
            end
         end
         if (best >= 0) begin
            hit = 1;
            dat = m_d[best];
         end else if (m_we && m_wa == q_addr) begin
            hit = 1;
            dat = m_wd;
         end
      end
   endtask

   always @(negedge clk) begin
      if (wb_we) rf_dut[wb_addr] <= wb_data;
      if (m_we)  rf_ref[m_wa]    <= m_wd;
   end

   always @(negedge clk) begin
      bit          eh;
      logic [31:0] ed;
      if (chk_en) begin
         exp_q(eh, ed);
         chk("wb_we",     {31'd0, wb_we}, {31'd0, m_we});
         chk("wb_addr",   {27'd0, wb_addr}, {27'd0, m_wa});
         chk("wb_data",   wb_data, m_wd);
         chk("req_ready", {30'd0, req_ready}, {30'd0, (!rst && !m_v[1]), (!rst && !m_v[0])});
         chk("idle",      {31'd0, idle}, {31'd0, (!m_we && !m_v[0] && !m_v[1])});
         chk("q_hit",     {31'd0, q_hit}, {31'd0, eh});
         chk("q_data",    q_data, ed);
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
      req_valid = v;
      req_addr  = {a1, a0};
      req_data  = {d1, d0};
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_dut[i] = '0;
         rf_ref[i] = '0;
      end
      m_v    = '{0, 0};
      m_a    = '{5'd0, 5'd0};
      m_d    = '{32'd0, 32'd0};
      m_st   = '{0, 0};
      m_we   = 0;
      m_wa   = '0;
      m_wd   = '0;
      m_rr   = 0;
      edge_n = 0;
      q_addr = '0;
      rst    = 1'b1;
      drive(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);

      // Reset held with both requesters asserting.
      cyc();
      chk_en = 1;
      #1;
      chk("rst_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_we",    {31'd0, wb_we}, 32'd0);
      chk("rst_idle",  {31'd0, idle}, 32'd1);
      cyc();
      chk("rst_ready2", {30'd0, req_ready}, 32'd0);
      chk("rst_addr",   {27'd0, wb_addr}, 32'd0);
      rst = 1'b0;
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      cyc();

      // Single ALU write.
      drive(2'b01, 5'd5, 32'h0000_00AA, 5'd0, 32'd0);
      cyc();
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      cyc();
      chk("alu_we",   {31'd0, wb_we}, 32'd1);
      chk("alu_addr", {27'd0, wb_addr}, 32'd5);
      chk("alu_data", wb_data, 32'h0000_00AA);
      @(negedge clk);
      #1;
      chk("rf_r5", rf_dut[5], 32'h0000_00AA);

      // Same-edge collision, twice; round-robin flips.
      drive(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
      cyc();
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      cyc();
      chk("col1_first",  {27'd0, wb_addr}, 32'd3);
      chk("col1_data",   wb_data, 32'h11);
      chk("model_rr",    m_rr, 32'd1);
      cyc();
      chk("col1_second", {27'd0, wb_addr}, 32'd4);
      drive(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
      cyc();
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      cyc();
      chk("col2_first",  {27'd0, wb_addr}, 32'd4);
      chk("col2_data",   wb_data, 32'h22);
      cyc();
      chk("col2_second", {27'd0, wb_addr}, 32'd3);

      // Age order and forwarding to the youngest pending write.
      drive(2'b10, 5'd0, 32'd0, 5'd7, 32'h1);
      cyc();
      drive(2'b01, 5'd7, 32'h2, 5'd0, 32'd0);
      cyc();
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      q_addr = 5'd7;
      #1;
      chk("age_wb_data", wb_data, 32'h1);
      chk("age_q_hit",   {31'd0, q_hit}, 32'd1);
      chk("age_q_data",  q_data, 32'h2);
      cyc();
      chk("age_wb2",     wb_data, 32'h2);
      chk("age_q2",      q_data, 32'h2);
      cyc();
      chk("age_drained", {31'd0, wb_we}, 32'd0);
      @(negedge clk);
      #1;
      chk("rf_r7", rf_dut[7], 32'h2);

      // R0 write is accepted and dropped.
      q_addr = 5'd0;
      drive(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0);
      #1;
      chk("r0_ready_pre", {31'd0, req_ready[0]}, 32'd1);
      cyc();
      chk("r0_ready",  {31'd0, req_ready[0]}, 32'd1);
      chk("r0_q_hit",  {31'd0, q_hit}, 32'd0);
      chk("r0_q_data", q_data, 32'd0);
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      cyc();
      chk("r0_we",   {31'd0, wb_we}, 32'd0);
      chk("r0_idle", {31'd0, idle}, 32'd1);

      // Mid-operation reset discards both slots.
      drive(2'b11, 5'd9, 32'h99, 5'd10, 32'hAB);
      cyc();
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      #1;
      chk("mid_full_idle", {31'd0, idle}, 32'd0);
      rst = 1'b1;
      cyc();
      chk("mid_rst_we", {31'd0, wb_we}, 32'd0);
      rst = 1'b0;
      cyc();
      chk("mid_we",   {31'd0, wb_we}, 32'd0);
      chk("mid_idle", {31'd0, idle}, 32'd1);
      @(negedge clk);
      #1;
      chk("rf_r9",  rf_dut[9], 32'd0);
      chk("rf_r10", rf_dut[10], 32'd0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 99) == 0);
         req_valid = 2'($urandom);
         req_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         req_data  = {$urandom, $urandom};
         q_addr    = 5'($urandom_range(0, 7));
         cyc();
      end
      rst = 1'b0;
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      repeat (4) cyc();
      @(negedge clk);
      #1;
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("rf_final[%0d]", i), rf_dut[i], rf_ref[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
